// File: rtl/ysyx_22050710_ifu_axil_if.sv
// Bus bundle between the fetch stage and its surroundings: AXI4-Lite read channel,
// the IDU instruction handshake, and the commit/redirect inputs.
interface ysyx_22050710_ifu_axil_if #(
  parameter int DW = 64
);
  // Every channel is valid/ready: a transfer happens on the rising edge where both are
  // high; a raised valid and its payload stay put until that edge (a flush may drop it).
  logic [63:0]   o_araddr;
  logic          o_arvalid;
  logic          i_arready;
  logic [DW-1:0] i_rdata;
  logic [1:0]    i_rresp;
  logic          i_rvalid;
  logic          o_rready;
  logic          o_valid;
  logic          i_ready;
  logic [63:0]   o_pc;
  logic [31:0]   o_inst;
  logic          i_nextpc_valid;
  logic [63:0]   i_nextpc;
  logic          i_flush;
  logic [63:0]   i_flush_pc;
  logic          o_fault;

  modport master (
    output o_araddr, o_arvalid, o_rready, o_valid, o_pc, o_inst, o_fault,
    input  i_arready, i_rdata, i_rresp, i_rvalid, i_ready,
           i_nextpc_valid, i_nextpc, i_flush, i_flush_pc
  );

  modport slave (
    input  o_araddr, o_arvalid, o_rready, o_valid, o_pc, o_inst, o_fault,
    output i_arready, i_rdata, i_rresp, i_rvalid, i_ready,
           i_nextpc_valid, i_nextpc, i_flush, i_flush_pc
  );
endinterface

// File: rtl/ysyx_22050710_ifu_axil.sv
// Multi-cycle NPC instruction fetch: one AXI4-Lite read at a time, {pc, inst} to the IDU,
// then wait for the committed next PC. Define YSYX_22050710_IFU_FAULT_EN for access faults.
module ysyx_22050710_ifu_axil #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DW       = 64
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  ysyx_22050710_ifu_axil_if.master        bus,
  output logic [2:0]                      o_dbg_state
);

`ifdef YSYX_22050710_IFU_FAULT_EN
  localparam bit FaultEn = 1'b1;
`else
  localparam bit FaultEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_AR    = 3'd0,
    S_R     = 3'd1,
    S_OUT   = 3'd2,
    S_NEXT  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic        arvalid_q, rready_q, valid_q;

  logic ar_hs, r_hs, out_hs;
  assign ar_hs  = arvalid_q & bus.i_arready;
  assign r_hs   = rready_q & bus.i_rvalid;
  assign out_hs = valid_q & bus.i_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    unique case (state_q)
      S_AR: begin
        if (bus.i_flush) begin
          pc_d = bus.i_flush_pc;
          // An address already accepted must still have its response consumed.
          if (ar_hs) state_d = S_DRAIN;
        end else if (ar_hs) begin
          state_d = S_R;
        end else if (FaultEn && (pc_q[1:0] != 2'b00)) begin
          state_d = S_OUT;
          inst_d  = 32'h0;
          fault_d = 1'b1;
        end
      end
      S_R: begin
        if (bus.i_flush) begin
          pc_d    = bus.i_flush_pc;
          state_d = r_hs ? S_AR : S_DRAIN;
        end else if (r_hs) begin
          state_d = S_OUT;
          if (FaultEn && (bus.i_rresp != 2'b00)) begin
            inst_d  = 32'h0;
            fault_d = 1'b1;
          end else begin
            inst_d  = pc_q[2] ? bus.i_rdata[DW-1 -: 32] : bus.i_rdata[31:0];
            fault_d = 1'b0;
          end
        end
      end
      S_OUT: begin
        if (bus.i_flush) begin
          pc_d    = bus.i_flush_pc;
          state_d = S_AR;
          fault_d = 1'b0;
        end else if (out_hs) begin
          state_d = S_NEXT;
          fault_d = 1'b0;
        end
      end
      S_NEXT: begin
        if (bus.i_flush) begin
          pc_d    = bus.i_flush_pc;
          state_d = S_AR;
        end else if (bus.i_nextpc_valid) begin
          pc_d    = bus.i_nextpc;
          state_d = S_AR;
        end
      end
      S_DRAIN: begin
        if (bus.i_flush) pc_d = bus.i_flush_pc;
        if (r_hs) state_d = S_AR;
      end
      default: state_d = S_AR;
    endcase
  end

  // Handshake outputs are registered from the next state so they drop on reset at once.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_AR;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      fault_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      fault_q   <= fault_d;
      arvalid_q <= (state_d == S_AR) && !(FaultEn && (pc_d[1:0] != 2'b00));
      rready_q  <= (state_d == S_R) || (state_d == S_DRAIN);
      valid_q   <= (state_d == S_OUT);
    end
  end

  assign bus.o_araddr  = {pc_q[63:3], 3'b000};
  assign bus.o_arvalid = arvalid_q;
  assign bus.o_rready  = rready_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_pc      = pc_q;
  assign bus.o_inst    = inst_q;
  assign bus.o_fault   = FaultEn ? fault_q : 1'b0;
  assign o_dbg_state   = state_q;

endmodule
